// File: rtl/uart_rx_param.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// uart_rx_param
//
// Parametrised UART receiver: DATA_BITS (5..8) data bits, optional odd/even
// parity, 1 or 2 stop bits. 16x oversampling with a 3-sample majority vote
// (samples 7, 8, 9 of each bit), glitch-rejected start detection, and
// frame/parity error pulses.
//
// Optional build macro: UART_RX_FIFO_EN
//   defined   -> FIFO_DEPTH-entry receive FIFO behind the frame decoder,
//                popped with rx_rd; overrun is sticky on a dropped word.
//   undefined -> rx_data holds the last word, rx_empty pulses low for one
//                cycle per word; rx_rd ignored, rx_full/overrun tied low.
//
// Ports
//   clk         system clock
//   rst         asynchronous active-low reset
//   rx          serial line, idle high, asynchronous to clk
//   rx_rd       pop request (FIFO build only)
//   rx_data     received word, LSB aligned, unused MSBs zero
//   rx_empty    low while rx_data holds an unread word
//   rx_full     FIFO full
//   overrun     sticky, a word was dropped
//   frame_err   one-cycle pulse on a bad stop bit
//   parity_err  one-cycle pulse on a parity mismatch
// -----------------------------------------------------------------------------
module uart_rx_param #(
    parameter int CLK_HZ     = 100_000_000,
    parameter int BAUD       = 9600,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    input  logic       rx_rd,
    output logic [7:0] rx_data,
    output logic       rx_empty,
    output logic       rx_full,
    output logic       overrun,
    output logic       frame_err,
    output logic       parity_err
);

    localparam int DIV = CLK_HZ / (BAUD * 16);
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] TICK_LAST = CW'(DIV - 1);
    localparam logic [2:0]    BIT_LAST  = 3'(DATA_BITS - 1);
    localparam logic          STOP_LAST = 1'(STOP_BITS - 1);
    localparam logic          PAR_ODD   = 1'(PARITY == 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_PAR   = 3'd3;
    localparam logic [2:0] S_STOP  = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    logic          rx_s1_q, rx_s2_q, rx_prev_q;
    logic [2:0]    state_q, state_d;
    logic [CW-1:0] tick_cnt_q, tick_cnt_d;
    logic [3:0]    samp_q, samp_d;
    logic          v7_q, v7_d, v8_q, v8_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic          stop_cnt_q, stop_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          par_bad_q, par_bad_d;
    logic          frm_bad_q, frm_bad_d;
    logic          frame_err_q, parity_err_q;

    logic fall, tick, vote_now, bit_end, vote, done, done_ok;

    // Both synchroniser flops and the edge-detect history reset to idle-high
    // so release of reset on an idle line never looks like a start edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_s1_q   <= 1'b1;
            rx_s2_q   <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_s1_q   <= rx;
            rx_s2_q   <= rx_s1_q;
            rx_prev_q <= rx_s2_q;
        end
    end

    assign fall     = rx_prev_q & ~rx_s2_q;
    assign tick     = (state_q != S_IDLE) && (tick_cnt_q == TICK_LAST);
    assign vote_now = tick && (samp_q == 4'd9);
    assign bit_end  = tick && (samp_q == 4'd15);
    // Samples 7 and 8 are held in v7/v8; sample 9 is the live synchronised bit.
    assign vote     = (v7_q & v8_q) | (v7_q & rx_s2_q) | (v8_q & rx_s2_q);
    assign done     = (state_q == S_DONE);
    assign done_ok  = done & ~frm_bad_q;

    always_comb begin
        state_d    = state_q;
        tick_cnt_d = tick_cnt_q;
        samp_d     = samp_q;
        v7_d       = v7_q;
        v8_d       = v8_q;
        bit_cnt_d  = bit_cnt_q;
        stop_cnt_d = stop_cnt_q;
        shift_d    = shift_q;
        par_bad_d  = par_bad_q;
        frm_bad_d  = frm_bad_q;

        if (state_q != S_IDLE) begin
            tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
        end
        if (tick) begin
            samp_d = samp_q + 4'd1;
            if (samp_q == 4'd7) v7_d = rx_s2_q;
            if (samp_q == 4'd8) v8_d = rx_s2_q;
        end

        case (state_q)
            S_IDLE: begin
                if (fall) begin
                    state_d    = S_START;
                    tick_cnt_d = '0;
                    samp_d     = '0;
                    bit_cnt_d  = '0;
                    stop_cnt_d = 1'b0;
                    shift_d    = '0;
                    par_bad_d  = 1'b0;
                    frm_bad_d  = 1'b0;
                end
            end
            S_START: begin
                // A start bit that votes high was only a glitch.
                if (vote_now && vote) state_d = S_IDLE;
                else if (bit_end)     state_d = S_DATA;
            end
            S_DATA: begin
                if (vote_now) begin
                    // LSB first: shift right, new bit enters at the top data
                    // position, so the bits above DATA_BITS-1 stay zero.
                    shift_d                = {1'b0, shift_q[7:1]};
                    shift_d[DATA_BITS-1]   = vote;
                end
                if (bit_end) begin
                    if (bit_cnt_q == BIT_LAST) state_d = (PARITY != 0) ? S_PAR : S_STOP;
                    else                       bit_cnt_d = bit_cnt_q + 3'd1;
                end
            end
            S_PAR: begin
                if (vote_now) par_bad_d = ((^shift_q) ^ vote) != PAR_ODD;
                if (bit_end)  state_d   = S_STOP;
            end
            S_STOP: begin
                // Leave right after the last stop vote so a following start
                // edge is caught even with no idle time between frames.
                if (vote_now) begin
                    if (!vote) frm_bad_d = 1'b1;
                    if (stop_cnt_q == STOP_LAST) state_d = S_DONE;
                end
                if (bit_end) stop_cnt_d = stop_cnt_q + 1'b1;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            tick_cnt_q   <= '0;
            samp_q       <= '0;
            v7_q         <= 1'b1;
            v8_q         <= 1'b1;
            bit_cnt_q    <= '0;
            stop_cnt_q   <= 1'b0;
            shift_q      <= '0;
            par_bad_q    <= 1'b0;
            frm_bad_q    <= 1'b0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            tick_cnt_q   <= tick_cnt_d;
            samp_q       <= samp_d;
            v7_q         <= v7_d;
            v8_q         <= v8_d;
            bit_cnt_q    <= bit_cnt_d;
            stop_cnt_q   <= stop_cnt_d;
            shift_q      <= shift_d;
            par_bad_q    <= par_bad_d;
            frm_bad_q    <= frm_bad_d;
            frame_err_q  <= done & frm_bad_q;
            parity_err_q <= done_ok & par_bad_q;
        end
    end

    assign frame_err  = frame_err_q;
    assign parity_err = parity_err_q;

`ifdef UART_RX_FIFO_EN
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    logic [7:0] mem_q [FIFO_DEPTH];
    logic [AW:0] wr_q, rd_q, count;
    logic        fifo_full, fifo_empty, pop, push;
    logic        overrun_q;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign count      = wr_q - rd_q;
    assign fifo_full  = (count == (AW+1)'(FIFO_DEPTH));
    assign fifo_empty = (count == '0);
    assign pop        = rx_rd & ~fifo_empty;
    assign push       = done_ok & (~fifo_full | pop);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
            wr_q      <= '0;
            rd_q      <= '0;
            overrun_q <= 1'b0;
        end else begin
            if (push) begin
                mem_q[wr_q[AW-1:0]] <= shift_q;
                wr_q                <= wr_q + 1'b1;
            end
            if (pop) rd_q <= rd_q + 1'b1;
            if (done_ok && fifo_full && !pop) overrun_q <= 1'b1;
        end
    end

    assign rx_data  = mem_q[rd_q[AW-1:0]];
    assign rx_empty = fifo_empty;
    assign rx_full  = fifo_full;
    assign overrun  = overrun_q;
`else
    logic [7:0] rx_data_q;
    logic       rx_empty_q;
    logic       unused_cfg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_data_q  <= '0;
            rx_empty_q <= 1'b1;
        end else begin
            if (done_ok) rx_data_q <= shift_q;
            rx_empty_q <= ~done_ok;
        end
    end

    assign rx_data    = rx_data_q;
    assign rx_empty   = rx_empty_q;
    assign rx_full    = 1'b0;
    assign overrun    = 1'b0;
    assign unused_cfg = ^{rx_rd, 32'(FIFO_DEPTH)};
`endif

endmodule

// File: tb/tb_uart_rx_param.sv
`timescale 1ns/1ps
module tb_uart_rx_param;

    localparam int CLK_HZ = 1_600_000;
    localparam int BAUD   = 10_000;
    localparam int DIV    = 10;
    localparam int BIT    = 16 * DIV;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rx_line [3] = '{1'b1, 1'b1, 1'b1};
    logic       rd_line [3] = '{1'b0, 1'b0, 1'b0};
    logic [7:0] data_o  [3];
    logic       empty_o [3];
    logic       full_o  [3];
    logic       ovr_o   [3];
    logic       fe_o    [3];
    logic       pe_o    [3];

    int checks    = 0;
    int errors    = 0;
    int cyc       = 0;
    int start_cyc = 0;
    int words    [3] = '{default: 0};
    int fe_cnt   [3] = '{default: 0};
    int pe_cnt   [3] = '{default: 0};
    int long_low [3] = '{default: 0};
    int del_cyc  [3] = '{default: 0};
    logic prev_low [3] = '{default: 1'b0};
    logic [7:0] wlog [3][32];

    // ch0: 8N1, ch1: 8 data even parity, ch2: 5 data odd parity 2 stop
    uart_rx_param #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .DATA_BITS(8), .PARITY(0),
                    .STOP_BITS(1), .FIFO_DEPTH(4)) u_a (
        .clk(clk), .rst(rst), .rx(rx_line[0]), .rx_rd(rd_line[0]),
        .rx_data(data_o[0]), .rx_empty(empty_o[0]), .rx_full(full_o[0]),
        .overrun(ovr_o[0]), .frame_err(fe_o[0]), .parity_err(pe_o[0]));
    uart_rx_param #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .DATA_BITS(8), .PARITY(2),
                    .STOP_BITS(1), .FIFO_DEPTH(4)) u_b (
        .clk(clk), .rst(rst), .rx(rx_line[1]), .rx_rd(rd_line[1]),
        .rx_data(data_o[1]), .rx_empty(empty_o[1]), .rx_full(full_o[1]),
        .overrun(ovr_o[1]), .frame_err(fe_o[1]), .parity_err(pe_o[1]));
    uart_rx_param #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .DATA_BITS(5), .PARITY(1),
                    .STOP_BITS(2), .FIFO_DEPTH(4)) u_c (
        .clk(clk), .rst(rst), .rx(rx_line[2]), .rx_rd(rd_line[2]),
        .rx_data(data_o[2]), .rx_empty(empty_o[2]), .rx_full(full_o[2]),
        .overrun(ovr_o[2]), .frame_err(fe_o[2]), .parity_err(pe_o[2]));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor: logs delivered words, error pulses and over-long
    // rx_empty low periods, sampled on the falling edge.
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (!empty_o[i]) begin
                if (words[i] < 32) wlog[i][words[i]] <= data_o[i];
                words[i]   <= words[i] + 1;
                del_cyc[i] <= cyc;
                if (prev_low[i]) long_low[i] <= long_low[i] + 1;
            end
            prev_low[i] <= !empty_o[i];
            if (fe_o[i]) fe_cnt[i] <= fe_cnt[i] + 1;
            if (pe_o[i]) pe_cnt[i] <= pe_cnt[i] + 1;
        end
    end

    // Drives one frame on channel ch. par < 0 means no parity bit.
    // gbit >= 0 inverts that bit only around its sample 8.
    task automatic send_frame(input int ch, input logic [7:0] d, input int nbits,
                              input int par, input logic last_stop, input int nstop,
                              input int gbit, input int idle);
        logic b [16];
        int n;
        b[0] = 1'b0;
        n = 1;
        for (int k = 0; k < nbits; k++) begin b[n] = d[k]; n++; end
        if (par >= 0) begin b[n] = par[0]; n++; end
        for (int s = 0; s < nstop; s++) begin
            b[n] = (s == nstop - 1) ? last_stop : 1'b1;
            n++;
        end
        $display("tx ch=%0d data=%02h par=%0d stop=%0b glitch_bit=%0d", ch, d, par, last_stop, gbit);
        start_cyc = cyc;
        for (int i = 0; i < n; i++) begin
            rx_line[ch] = b[i];
            if (i == gbit) begin
                repeat (86) @(posedge clk); #1;
                rx_line[ch] = ~b[i];
                repeat (10) @(posedge clk); #1;
                rx_line[ch] = b[i];
                repeat (BIT - 96) @(posedge clk); #1;
            end else begin
                repeat (BIT) @(posedge clk); #1;
            end
        end
        rx_line[ch] = 1'b1;
        if (idle > 0) begin
            repeat (idle) @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(posedge clk); #1;
        checks++; if (data_o[0] !== 8'h00) begin errors++; $display("FAIL reset_data: got %02h expected 00", data_o[0]); end
        checks++; if (empty_o[0] !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b expected 1", empty_o[0]); end
        checks++; if (full_o[0] !== 1'b0) begin errors++; $display("FAIL reset_full: got %b expected 0", full_o[0]); end
        checks++; if (ovr_o[0] !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b expected 0", ovr_o[0]); end
        checks++; if (fe_o[0] !== 1'b0) begin errors++; $display("FAIL reset_frame_err: got %b expected 0", fe_o[0]); end
        checks++; if (pe_o[0] !== 1'b0) begin errors++; $display("FAIL reset_parity_err: got %b expected 0", pe_o[0]); end
        checks++; if (empty_o[1] !== 1'b1 || empty_o[2] !== 1'b1) begin errors++; $display("FAIL reset_empty_b_c: got %b%b expected 11", empty_o[1], empty_o[2]); end
        rst = 1'b1;
        repeat (5) @(posedge clk); #1;
        $display("reset released");
    endtask

`ifdef UART_RX_FIFO_EN
    task automatic test_fifo();
        for (int k = 1; k <= 4; k++) send_frame(0, 8'(k), 8, -1, 1'b1, 1, -1, 0);
        checks++; if (full_o[0] !== 1'b1) begin errors++; $display("FAIL fifo_full_after_4: got %b expected 1", full_o[0]); end
        checks++; if (ovr_o[0] !== 1'b0) begin errors++; $display("FAIL fifo_overrun_after_4: got %b expected 0", ovr_o[0]); end
        send_frame(0, 8'h05, 8, -1, 1'b1, 1, -1, BIT);
        checks++; if (ovr_o[0] !== 1'b1) begin errors++; $display("FAIL fifo_overrun_after_5: got %b expected 1", ovr_o[0]); end
        checks++; if (full_o[0] !== 1'b1) begin errors++; $display("FAIL fifo_full_after_5: got %b expected 1", full_o[0]); end
        for (int k = 1; k <= 4; k++) begin
            checks++;
            if (empty_o[0] !== 1'b0 || data_o[0] !== 8'(k)) begin
                errors++;
                $display("FAIL fifo_pop_%0d: got empty=%b data=%02h expected empty=0 data=%02h", k, empty_o[0], data_o[0], 8'(k));
            end
            $display("pop %0d data=%02h", k, data_o[0]);
            rd_line[0] = 1'b1;
            @(posedge clk); #1;
            rd_line[0] = 1'b0;
        end
        checks++; if (empty_o[0] !== 1'b1) begin errors++; $display("FAIL fifo_empty_after_pops: got %b expected 1", empty_o[0]); end
        checks++; if (full_o[0] !== 1'b0) begin errors++; $display("FAIL fifo_not_full_after_pops: got %b expected 0", full_o[0]); end
        rd_line[0] = 1'b1;
        @(posedge clk); #1;
        rd_line[0] = 1'b0;
        checks++; if (empty_o[0] !== 1'b1 || ovr_o[0] !== 1'b1) begin errors++; $display("FAIL fifo_pop_when_empty: got empty=%b overrun=%b expected 1 1", empty_o[0], ovr_o[0]); end
    endtask
`else
    task automatic test_basic();
        int w, fe, pe, ll, lat;
        w = words[0]; fe = fe_cnt[0]; pe = pe_cnt[0]; ll = long_low[0];
        send_frame(0, 8'h53, 8, -1, 1'b1, 1, -1, BIT);
        lat = del_cyc[0] - start_cyc;
        checks++; if (words[0] - w !== 1) begin errors++; $display("FAIL basic_count: got %0d words expected 1", words[0] - w); end
        checks++; if (wlog[0][w] !== 8'h53) begin errors++; $display("FAIL basic_data: got %02h expected 53", wlog[0][w]); end
        checks++; if (fe_cnt[0] != fe || pe_cnt[0] != pe) begin errors++; $display("FAIL basic_flags: got fe=%0d pe=%0d expected 0 0", fe_cnt[0] - fe, pe_cnt[0] - pe); end
        checks++; if (long_low[0] != ll) begin errors++; $display("FAIL basic_empty_width: got %0d extra low cycles expected 0", long_low[0] - ll); end
        checks++; if (lat < 1543 - DIV || lat > 1543 + DIV) begin errors++; $display("FAIL basic_latency: got %0d expected 1543 +/- %0d", lat, DIV); end
    endtask

    task automatic test_vote();
        int w;
        w = words[0];
        send_frame(0, 8'h53, 8, -1, 1'b1, 1, 1, BIT);
        send_frame(0, 8'hAC, 8, -1, 1'b1, 1, 1, BIT);
        checks++; if (words[0] - w !== 2) begin errors++; $display("FAIL vote_count: got %0d words expected 2", words[0] - w); end
        checks++; if (wlog[0][w] !== 8'h53) begin errors++; $display("FAIL vote_low_glitch: got %02h expected 53", wlog[0][w]); end
        checks++; if (wlog[0][w+1] !== 8'hAC) begin errors++; $display("FAIL vote_high_glitch: got %02h expected AC", wlog[0][w+1]); end
    endtask

    task automatic test_parity();
        int w, pe, fe, lat;
        w = words[1]; pe = pe_cnt[1]; fe = fe_cnt[1];
        send_frame(1, 8'h53, 8, 0, 1'b1, 1, -1, BIT);
        checks++; if (words[1] - w !== 1 || data_o[1] !== 8'h53) begin errors++; $display("FAIL even_good: got %0d words data=%02h expected 1 53", words[1] - w, data_o[1]); end
        checks++; if (pe_cnt[1] != pe) begin errors++; $display("FAIL even_good_pe: got %0d pulses expected 0", pe_cnt[1] - pe); end
        send_frame(1, 8'h53, 8, 1, 1'b1, 1, -1, BIT);
        checks++; if (words[1] - w !== 2 || data_o[1] !== 8'h53) begin errors++; $display("FAIL even_bad: got %0d words data=%02h expected 2 53", words[1] - w, data_o[1]); end
        checks++; if (pe_cnt[1] - pe !== 1 || fe_cnt[1] != fe) begin errors++; $display("FAIL even_bad_pe: got pe=%0d fe=%0d expected 1 0", pe_cnt[1] - pe, fe_cnt[1] - fe); end

        w = words[2]; pe = pe_cnt[2]; fe = fe_cnt[2];
        send_frame(2, 8'h15, 5, 0, 1'b1, 2, -1, BIT);
        lat = del_cyc[2] - start_cyc;
        checks++; if (words[2] - w !== 1 || data_o[2] !== 8'h15 || pe_cnt[2] != pe) begin errors++; $display("FAIL odd5_good: got %0d words data=%02h pe=%0d expected 1 15 0", words[2] - w, data_o[2], pe_cnt[2] - pe); end
        checks++; if (lat < 1383 - DIV || lat > 1383 + DIV) begin errors++; $display("FAIL odd5_latency: got %0d expected 1383 +/- %0d", lat, DIV); end
        send_frame(2, 8'h0C, 5, 0, 1'b1, 2, -1, BIT);
        checks++; if (data_o[2] !== 8'h0C || pe_cnt[2] - pe !== 1) begin errors++; $display("FAIL odd5_bad: got data=%02h pe=%0d expected 0C 1", data_o[2], pe_cnt[2] - pe); end
        send_frame(2, 8'h1A, 5, 0, 1'b0, 2, -1, BIT);
        checks++; if (fe_cnt[2] - fe !== 1 || words[2] - w !== 2 || data_o[2] !== 8'h0C) begin errors++; $display("FAIL odd5_stop2: got fe=%0d words=%0d data=%02h expected 1 2 0C", fe_cnt[2] - fe, words[2] - w, data_o[2]); end
    endtask

    task automatic test_frame_err();
        int w, fe;
        w = words[0]; fe = fe_cnt[0];
        send_frame(0, 8'hA5, 8, -1, 1'b0, 1, -1, 0);
        rx_line[0] = 1'b0;              // hold a break after the bad stop bit
        repeat (400) @(posedge clk); #1;
        rx_line[0] = 1'b1;
        repeat (300) @(posedge clk); #1;
        checks++; if (fe_cnt[0] - fe !== 1) begin errors++; $display("FAIL frame_err_pulses: got %0d expected 1", fe_cnt[0] - fe); end
        checks++; if (words[0] - w !== 0 || empty_o[0] !== 1'b1) begin errors++; $display("FAIL frame_err_discard: got %0d words empty=%b expected 0 1", words[0] - w, empty_o[0]); end
        checks++; if (data_o[0] !== 8'hAC) begin errors++; $display("FAIL frame_err_hold: got %02h expected AC", data_o[0]); end
        send_frame(0, 8'h31, 8, -1, 1'b1, 1, -1, BIT);
        checks++; if (words[0] - w !== 1 || wlog[0][w] !== 8'h31 || fe_cnt[0] - fe !== 1) begin errors++; $display("FAIL frame_err_recover: got %0d words data=%02h fe=%0d expected 1 31 1", words[0] - w, wlog[0][w], fe_cnt[0] - fe); end
    endtask

    task automatic test_glitch();
        int w, fe, pe;
        w = words[0]; fe = fe_cnt[0]; pe = pe_cnt[0];
        $display("glitch ch=0 low 5 cycles");
        rx_line[0] = 1'b0;
        repeat (5) @(posedge clk); #1;
        rx_line[0] = 1'b1;
        repeat (400) @(posedge clk); #1;
        checks++; if (words[0] != w || fe_cnt[0] != fe || pe_cnt[0] != pe) begin errors++; $display("FAIL glitch_quiet: got words=%0d fe=%0d pe=%0d expected 0 0 0", words[0] - w, fe_cnt[0] - fe, pe_cnt[0] - pe); end
        send_frame(0, 8'h0F, 8, -1, 1'b1, 1, -1, BIT);
        checks++; if (words[0] - w !== 1 || wlog[0][w] !== 8'h0F) begin errors++; $display("FAIL glitch_recover: got %0d words data=%02h expected 1 0F", words[0] - w, wlog[0][w]); end
    endtask

    task automatic test_back_to_back();
        int w, ll;
        w = words[0]; ll = long_low[0];
        send_frame(0, 8'h11, 8, -1, 1'b1, 1, -1, 0);
        send_frame(0, 8'h22, 8, -1, 1'b1, 1, -1, BIT);
        checks++; if (words[0] - w !== 2) begin errors++; $display("FAIL b2b_count: got %0d words expected 2", words[0] - w); end
        checks++; if (wlog[0][w] !== 8'h11 || wlog[0][w+1] !== 8'h22) begin errors++; $display("FAIL b2b_data: got %02h %02h expected 11 22", wlog[0][w], wlog[0][w+1]); end
        checks++; if (long_low[0] != ll) begin errors++; $display("FAIL b2b_empty_width: got %0d extra low cycles expected 0", long_low[0] - ll); end
    endtask

    task automatic test_reset_mid();
        int w;
        w = words[0];
        fork
            send_frame(0, 8'hF0, 8, -1, 1'b1, 1, -1, BIT);
            begin
                repeat (BIT * 6 + BIT / 2) @(posedge clk); #1;
                rst = 1'b0;
                repeat (3) @(posedge clk); #1;
                checks++; if (data_o[0] !== 8'h00 || empty_o[0] !== 1'b1) begin errors++; $display("FAIL midreset_outputs: got data=%02h empty=%b expected 00 1", data_o[0], empty_o[0]); end
                checks++; if (fe_o[0] !== 1'b0 || pe_o[0] !== 1'b0 || data_o[1] !== 8'h00) begin errors++; $display("FAIL midreset_flags: got fe=%b pe=%b data_b=%02h expected 0 0 00", fe_o[0], pe_o[0], data_o[1]); end
                rst = 1'b1;
                $display("reset pulsed mid-frame");
            end
        join
        checks++; if (words[0] != w) begin errors++; $display("FAIL midreset_no_word: got %0d words expected 0", words[0] - w); end
        send_frame(0, 8'h7E, 8, -1, 1'b1, 1, -1, BIT);
        checks++; if (words[0] - w !== 1 || wlog[0][w] !== 8'h7E) begin errors++; $display("FAIL midreset_recover: got %0d words data=%02h expected 1 7E", words[0] - w, wlog[0][w]); end
    endtask
`endif

    initial begin
        test_reset();
`ifdef UART_RX_FIFO_EN
        test_fifo();
`else
        test_basic();
        test_vote();
        test_parity();
        test_frame_err();
        test_glitch();
        test_back_to_back();
        test_reset_mid();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
